// File: rtl/fp_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fp_op_sequencer
//  Purpose  : Buffers FP operation requests in a small FIFO, issues them one at
//             a time to the arithmetic unit and holds each result for the consumer.
//  Revision : 1.0  initial release
// ============================================================================
module fp_op_sequencer #(
   parameter int SIGN_W = 1,
   parameter int EXPO_W = 8,
   parameter int MANT_W = 23,
   parameter int DEPTH  = 4,
   parameter int LAT    = 3,
   localparam int W     = SIGN_W + EXPO_W + MANT_W,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [W-1:0]     req_a,
   input  logic [W-1:0]     req_b,
   input  logic [1:0]       req_rnd,
   input  logic             req_op,
   output logic             iss_valid,
   output logic [W-1:0]     iss_a,
   output logic [W-1:0]     iss_b,
   output logic [1:0]       iss_rnd,
   output logic             iss_op,
   input  logic [W-1:0]     unit_res,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [W-1:0]     rsp_res,
   output logic             rsp_op,
   output logic [CNT_W-1:0] fifo_cnt,
   output logic             busy
);

   localparam int EW    = 2 * W + 3;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LCW   = $clog2(LAT + 1);
   localparam logic [LCW-1:0]   c_LAT   = LCW'(LAT);
   localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_push;
   logic             w_pop;
   logic             w_capture;
   logic             w_fifo_ne;
   logic [EW-1:0]    r_mem [DEPTH];
   logic [EW-1:0]    w_head;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic [LCW-1:0]   r_wait;

   // Ready depends on occupancy only, never on the response side.
   assign req_ready = (r_cnt < c_DEPTH);
   assign w_push    = req_valid && req_ready;
   assign w_fifo_ne = (r_cnt != '0);
   assign w_head    = r_mem[r_rd_ptr];
   assign fifo_cnt  = r_cnt;
   assign iss_valid = (r_state == S_WAIT);
   assign rsp_valid = (r_state == S_RESP);
   assign busy      = (r_state != S_IDLE) || w_fifo_ne;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_fifo_ne) begin
               w_pop       = 1'b1;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_wait == LCW'(1)) begin
               w_capture   = 1'b1;
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_pop       = w_fifo_ne;
               w_state_nxt = w_fifo_ne ? S_WAIT : S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Storage is not reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {req_a, req_b, req_rnd, req_op};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_a   <= '0;
         iss_b   <= '0;
         iss_rnd <= '0;
         iss_op  <= 1'b0;
         r_wait  <= '0;
         rsp_res <= '0;
         rsp_op  <= 1'b0;
      end else begin
         if (w_pop) begin
            {iss_a, iss_b, iss_rnd, iss_op} <= w_head;
            r_wait <= c_LAT;
         end else if (r_state == S_WAIT) begin
            r_wait <= r_wait - LCW'(1);
         end
         if (w_capture) begin
            rsp_res <= unit_res;
            rsp_op  <= iss_op;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fp_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_op_sequencer
//  Purpose  : Directed self-checking bench for fp_op_sequencer (LAT=3 and LAT=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_op_sequencer;

   localparam int LAT3 = 3;
   localparam int LAT1 = 1;

   logic clk, rst_n;
   int   n_vec, n_err;

   // LAT=3 instance
   logic        req_valid, req_ready, req_op, iss_valid, iss_op, rsp_valid, rsp_ready, rsp_op, busy;
   logic [31:0] req_a, req_b, iss_a, iss_b, unit_res, rsp_res;
   logic [1:0]  req_rnd, iss_rnd;
   logic [2:0]  fifo_cnt;
   // LAT=1 instance
   logic        req_valid1, req_ready1, req_op1, iss_valid1, iss_op1, rsp_valid1, rsp_ready1, rsp_op1, busy1;
   logic [31:0] req_a1, req_b1, iss_a1, iss_b1, unit_res1, rsp_res1;
   logic [1:0]  req_rnd1, iss_rnd1;
   logic [2:0]  fifo_cnt1;

   int run3, run1;

   // Unit stand-in: known FP results for 1.0/2.0, otherwise a deterministic hash.
   function automatic logic [31:0] unit_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] rnd, input logic op);
      if (a == 32'h3F800000 && b == 32'h40000000) return op ? 32'h40400000 : 32'h40000000;
      return op ? (a + b + {30'd0, rnd}) : ((a ^ b) + {30'd0, rnd} + 32'h100);
   endfunction

   // Result is only valid in the LAT-th cycle of presentation.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) run3 <= 0; else run3 <= iss_valid ? run3 + 1 : 0;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) run1 <= 0; else run1 <= iss_valid1 ? run1 + 1 : 0;
   assign unit_res  = (iss_valid  && run3 == LAT3 - 1) ? unit_fn(iss_a, iss_b, iss_rnd, iss_op) : 32'hBAD0BAD0;
   assign unit_res1 = (iss_valid1 && run1 == LAT1 - 1) ? unit_fn(iss_a1, iss_b1, iss_rnd1, iss_op1) : 32'hBAD0BAD0;

   fp_op_sequencer #(.DEPTH(4), .LAT(LAT3)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_rnd(req_rnd), .req_op(req_op),
      .iss_valid(iss_valid), .iss_a(iss_a), .iss_b(iss_b), .iss_rnd(iss_rnd), .iss_op(iss_op),
      .unit_res(unit_res), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_res(rsp_res), .rsp_op(rsp_op), .fifo_cnt(fifo_cnt), .busy(busy));

   fp_op_sequencer #(.DEPTH(4), .LAT(LAT1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_a(req_a1), .req_b(req_b1), .req_rnd(req_rnd1), .req_op(req_op1),
      .iss_valid(iss_valid1), .iss_a(iss_a1), .iss_b(iss_b1), .iss_rnd(iss_rnd1), .iss_op(iss_op1),
      .unit_res(unit_res1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
      .rsp_res(rsp_res1), .rsp_op(rsp_op1), .fifo_cnt(fifo_cnt1), .busy(busy1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push3(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rnd, input logic op);
      int n = 0;
      req_a = a; req_b = b; req_rnd = rnd; req_op = op; req_valid = 1'b1;
      while (!req_ready && n < 100) begin tick(); n++; end
      if (!req_ready) chk("push_timeout", 32'd0, 32'd1);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp3();
      int n = 0;
      while (!rsp_valid && n < 50) begin tick(); n++; end
      if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
   endtask

   task automatic consume3();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   logic [31:0] fa [6], fb [6], fexp [6];
   logic        fop [6];
   logic [31:0] q_res[$];
   logic        q_op[$];

   initial begin
      n_vec = 0; n_err = 0;
      rst_n = 1'b0;
      req_valid = 0; req_a = 0; req_b = 0; req_rnd = 0; req_op = 0; rsp_ready = 0;
      req_valid1 = 0; req_a1 = 0; req_b1 = 0; req_rnd1 = 0; req_op1 = 0; rsp_ready1 = 0;
      #12;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_iss_valid", {31'd0, iss_valid}, 32'd0);
      chk("rst_iss_a", iss_a, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_res", rsp_res, 32'd0);
      chk("rst_fifo_cnt", {29'd0, fifo_cnt}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Single mul on the LAT=1 instance
      req_a1 = 32'h3F800000; req_b1 = 32'h40000000; req_rnd1 = 2'd0; req_op1 = 1'b0; req_valid1 = 1'b1;
      chk("l1_ready", {31'd0, req_ready1}, 32'd1);
      tick(); req_valid1 = 1'b0;
      chk("l1_iss_t1", {31'd0, iss_valid1}, 32'd0);
      chk("l1_busy_t1", {31'd0, busy1}, 32'd1);
      tick();
      chk("l1_iss_t2", {31'd0, iss_valid1}, 32'd1);
      chk("l1_rsp_t2", {31'd0, rsp_valid1}, 32'd0);
      tick();
      chk("l1_rsp_t3", {31'd0, rsp_valid1}, 32'd1);
      chk("l1_res", rsp_res1, 32'h40000000);
      chk("l1_op", {31'd0, rsp_op1}, 32'd0);
      rsp_ready1 = 1'b1; tick(); rsp_ready1 = 1'b0;
      chk("l1_busy_done", {31'd0, busy1}, 32'd0);

      // Single add on the LAT=3 instance
      req_a = 32'h3F800000; req_b = 32'h40000000; req_rnd = 2'd0; req_op = 1'b1; req_valid = 1'b1;
      tick(); req_valid = 1'b0;
      chk("l3_iss_t1", {31'd0, iss_valid}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("l3_iss_wait", {31'd0, iss_valid}, 32'd1);
         chk("l3_rsp_wait", {31'd0, rsp_valid}, 32'd0);
      end
      tick();
      chk("l3_rsp_t5", {31'd0, rsp_valid}, 32'd1);
      chk("l3_iss_t5", {31'd0, iss_valid}, 32'd0);
      chk("l3_res", rsp_res, 32'h40400000);
      chk("l3_op", {31'd0, rsp_op}, 32'd1);
      consume3();
      chk("l3_idle", {31'd0, busy}, 32'd0);

      // Response hold with one queued request
      push3(32'h3F800000, 32'h40000000, 2'd0, 1'b1);
      push3(32'h12345678, 32'h0F0F0F0F, 2'd2, 1'b0);
      wait_rsp3();
      for (int i = 0; i < 10; i++) begin
         chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
         chk("hold_res", rsp_res, 32'h40400000);
         chk("hold_op", {31'd0, rsp_op}, 32'd1);
         chk("hold_cnt", {29'd0, fifo_cnt}, 32'd1);
         tick();
      end
      consume3();
      chk("hold_one_hs_valid", {31'd0, rsp_valid}, 32'd0);
      chk("hold_one_hs_iss", {31'd0, iss_valid}, 32'd1);
      chk("hold_one_hs_cnt", {29'd0, fifo_cnt}, 32'd0);
      wait_rsp3();
      chk("hold_res2", rsp_res, 32'h1D3B5A79);
      chk("hold_op2", {31'd0, rsp_op}, 32'd0);
      consume3();
      chk("hold_done", {31'd0, busy}, 32'd0);

      // Fill and stall
      for (int i = 0; i < 6; i++) begin
         fa[i] = 32'h01000000 * (i + 1) + 32'h55;
         fb[i] = 32'h00030000 * (i + 7);
         fop[i] = i[0];
         fexp[i] = unit_fn(fa[i], fb[i], 2'(i), fop[i]);
      end
      for (int i = 0; i < 5; i++) push3(fa[i], fb[i], 2'(i), fop[i]);
      req_a = fa[5]; req_b = fb[5]; req_rnd = 2'd1; req_op = fop[5]; req_valid = 1'b1;
      repeat (6) tick();
      chk("fill_ready", {31'd0, req_ready}, 32'd0);
      chk("fill_cnt", {29'd0, fifo_cnt}, 32'd4);
      chk("fill_rsp0", rsp_res, fexp[0]);
      rsp_ready = 1'b1;
      begin
         int cyc = 0, got = 0, last = 0;
         logic hs_req;
         while (got < 6 && cyc < 200) begin
            if (cyc == 0) chk("fill_ready_pop", {31'd0, req_ready}, 32'd0);
            if (cyc == 1) chk("fill_ready_after", {31'd0, req_ready}, 32'd1);
            if (rsp_valid) begin
               chk("fill_res", rsp_res, fexp[got]);
               chk("fill_op", {31'd0, rsp_op}, {31'd0, fop[got]});
               if (got > 0) chk("fill_spacing", cyc - last, LAT3 + 1);
               last = cyc;
               got++;
            end
            hs_req = req_valid && req_ready;
            tick(); cyc++;
            if (hs_req) req_valid = 1'b0;
         end
         chk("fill_count", got, 6);
      end
      rsp_ready = 1'b0;
      tick();

      // Reset in WAIT with three queued entries
      for (int i = 0; i < 4; i++) push3(fa[i], fb[i], 2'd0, 1'b1);
      chk("mid_iss_valid", {31'd0, iss_valid}, 32'd1);
      chk("mid_cnt", {29'd0, fifo_cnt}, 32'd3);
      rst_n = 1'b0;
      #1;
      chk("arst_iss_valid", {31'd0, iss_valid}, 32'd0);
      chk("arst_iss_a", iss_a, 32'd0);
      chk("arst_cnt", {29'd0, fifo_cnt}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_ready", {31'd0, req_ready}, 32'd1);
      tick();
      rst_n = 1'b1;
      begin
         int stale = 0;
         for (int i = 0; i < 10; i++) begin
            if (rsp_valid || iss_valid) stale++;
            tick();
         end
         chk("arst_no_stale", stale, 0);
      end
      push3(32'h3F800000, 32'h40000000, 2'd0, 1'b0);
      wait_rsp3();
      chk("arst_new_res", rsp_res, 32'h40000000);
      consume3();

      // Random mixed traffic with random back-pressure
      begin
         int sent = 0, got = 0, maxc = 0;
         logic acc;
         for (int c = 0; c < 3000 && got < 20; c++) begin
            if (sent < 20 && !req_valid) begin
               req_a = $urandom; req_b = $urandom;
               req_rnd = 2'($urandom_range(0, 3)); req_op = 1'($urandom_range(0, 1));
               req_valid = 1'b1;
            end
            rsp_ready = 1'($urandom_range(0, 1));
            if (int'(fifo_cnt) > maxc) maxc = int'(fifo_cnt);
            if (rsp_valid && rsp_ready) begin
               if (q_res.size() == 0) chk("rand_extra", 32'd1, 32'd0);
               else begin
                  chk("rand_res", rsp_res, q_res.pop_front());
                  chk("rand_op", {31'd0, rsp_op}, {31'd0, q_op.pop_front()});
               end
               got++;
            end
            acc = req_valid && req_ready;
            if (acc) begin
               q_res.push_back(unit_fn(req_a, req_b, req_rnd, req_op));
               q_op.push_back(req_op);
               sent++;
            end
            tick();
            if (acc) req_valid = 1'b0;
         end
         rsp_ready = 1'b0;
         chk("rand_got", got, 20);
         chk("rand_maxcnt_ok", {31'd0, maxc <= 4}, 32'd1);
         chk("rand_left", q_res.size(), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
